// File: rtl/imem_bank_if.sv
// ----------------------------------------------------------------------------
// imem_bank_if
//  Bundles the clear control, the program-load port and the fetch
//  request/response handshake of the instruction memory bank.
//  master : fetch stage / loader side (drives requests, loads, clr_start)
//  slave  : memory side (imem_bank)
//  Signals:
//   clr_start            pulse, re-clear whole memory
//   busy                 high while clearing
//   ld_valid/ld_ready    load handshake, ld_addr word index, ld_data word
//   req_valid/req_ready  fetch request handshake, req_addr byte address
//   rsp_valid/rsp_ready  fetch response handshake, rsp_data, rsp_fault
// ----------------------------------------------------------------------------
interface imem_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int AW     = 6
);
    logic              clr_start;
    logic              busy;
    logic              ld_valid;
    logic              ld_ready;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fault;

    modport master (
        output clr_start, ld_valid, ld_addr, ld_data, req_valid, req_addr, rsp_ready,
        input  busy, ld_ready, req_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  clr_start, ld_valid, ld_addr, ld_data, req_valid, req_addr, rsp_ready,
        output busy, ld_ready, req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/imem_bank.sv
// ----------------------------------------------------------------------------
// imem_bank
//  Parametrised instruction memory sitting between the fetch stage and decode.
//  After reset (or a clr_start pulse) every word is overwritten with NOP_WORD,
//  one word per cycle, before the ports open. Words can be loaded at run time
//  through the load port. Fetches are byte-addressed with a one-cycle
//  registered response; misaligned or out-of-range fetches return NOP_WORD
//  with rsp_fault set.
//  Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    imem_bank_if slave modport (clear, load, fetch req/rsp)
// ----------------------------------------------------------------------------
module imem_bank #(
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 64,
    parameter int                 ADDR_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = 32'h00000013,
    localparam int                AW       = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    imem_bank_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     cnt_r;
    logic [AW-1:0]     cnt_nxt_s;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_fault_r;

    logic              run_s;
    logic              enter_clear_s;
    logic              ld_fire_s;
    logic              req_fire_s;
    logic              fault_s;
    logic [AW-1:0]     idx_s;

    assign run_s         = (state_r == ST_RUN);
    assign enter_clear_s = run_s & bus.clr_start;
    assign ld_fire_s     = bus.ld_valid & run_s;
    assign req_fire_s    = bus.req_valid & bus.req_ready;
    assign idx_s         = bus.req_addr[AW+1:2];
    // Any bit above the word index makes the address fall outside the bank.
    assign fault_s       = (bus.req_addr[1:0] != 2'b00) |
                           ((bus.req_addr >> (AW + 2)) != '0);

    assign bus.busy      = ~run_s;
    assign bus.ld_ready  = run_s;
    assign bus.req_ready = run_s & (~rsp_valid_r | bus.rsp_ready);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_fault = rsp_fault_r;

    // State and clear-counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic: sweep every word once, then run until clr_start.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + AW'(1);
                end
            end
            ST_RUN: begin
                if (bus.clr_start) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = '0;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Storage array: no reset so it maps onto a RAM; clear sweep has priority.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= NOP_WORD;
        end else if (ld_fire_s) begin
            mem_r[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Fetch response register. The read uses the pre-edge array contents,
    // so a same-cycle load to the fetched word returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_fault_r <= 1'b0;
        end else if (enter_clear_s) begin
            rsp_valid_r <= 1'b0;
        end else if (req_fire_s) begin
            rsp_valid_r <= 1'b1;
            rsp_fault_r <= fault_s;
            rsp_data_r  <= fault_s ? NOP_WORD : mem_r[idx_s];
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_bank.sv
module tb_imem_bank;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;
    localparam int AW     = 6;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset;

    imem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AW(AW)) bus ();

    imem_bank #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .NOP_WORD(NOP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;

    typedef struct {
        logic          ld_v;
        logic [AW-1:0] ld_a;
        logic [31:0]   ld_d;
        logic          rq_v;
        logic [31:0]   rq_a;
        logic          exp_v;
        logic [31:0]   exp_d;
        logic          exp_f;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic ld_v, logic [AW-1:0] ld_a, logic [31:0] ld_d,
                                logic rq_v, logic [31:0] rq_a,
                                logic exp_v, logic [31:0] exp_d, logic exp_f);
        vec_t v;
        v.ld_v = ld_v; v.ld_a = ld_a; v.ld_d = ld_d;
        v.rq_v = rq_v; v.rq_a = rq_a;
        v.exp_v = exp_v; v.exp_d = exp_d; v.exp_f = exp_f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy falls, bounded.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.busy && n < 200);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        n_vec  = 0;
        n_miss = 0;

        vecs[0]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0000, 1'b1, NOP,           1'b0);
        vecs[1]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0004, 1'b1, NOP,           1'b0);
        vecs[2]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0008, 1'b1, NOP,           1'b0);
        vecs[3]  = mk(1'b1, 6'd4,  32'h019806B3, 1'b0, 32'h0000_0000, 1'b0, NOP,           1'b0);
        vecs[4]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h019806B3,  1'b0);
        vecs[5]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0012, 1'b1, NOP,           1'b1);
        vecs[6]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0100, 1'b1, NOP,           1'b1);
        vecs[7]  = mk(1'b1, 6'd63, 32'hCAFE0001, 1'b1, 32'h0000_00FC, 1'b1, NOP,           1'b0);
        vecs[8]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_00FC, 1'b1, 32'hCAFE0001,  1'b0);
        vecs[9]  = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h8000_0000, 1'b1, NOP,           1'b1);
        vecs[10] = mk(1'b1, 6'd8,  32'h40340293, 1'b1, 32'h0000_0020, 1'b1, NOP,           1'b0);
        vecs[11] = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0020, 1'b1, 32'h40340293,  1'b0);
        vecs[12] = mk(1'b0, 6'd0,  32'h0,        1'b1, 32'h0000_0001, 1'b1, NOP,           1'b1);
        vecs[13] = mk(1'b0, 6'd0,  32'h0,        1'b0, 32'h0000_0000, 1'b0, NOP,           1'b0);

        reset         = 1'b1;
        bus.clr_start = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;

        tick();
        tick();
        chk("reset_busy",      32'(bus.busy),      32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data",  bus.rsp_data,       32'h0);
        chk("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("reset_ld_ready",  32'(bus.ld_ready),  32'd0);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

        reset = 1'b0;
        count_busy(n);
        chk("clear_cycles",    32'(n),             32'd64);
        chk("run_ld_ready",    32'(bus.ld_ready),  32'd1);
        chk("run_req_ready",   32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            bus.ld_valid  = vecs[i].ld_v;
            bus.ld_addr   = vecs[i].ld_a;
            bus.ld_data   = vecs[i].ld_d;
            bus.req_valid = vecs[i].rq_v;
            bus.req_addr  = vecs[i].rq_a;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                chk($sformatf("vec%0d_data", i),  bus.rsp_data,       vecs[i].exp_d);
                chk($sformatf("vec%0d_fault", i), 32'(bus.rsp_fault), 32'(vecs[i].exp_f));
            end
        end
        bus.ld_valid  = 1'b0;
        bus.req_valid = 1'b0;

        // Back-pressure: response must hold while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0010;
        tick();
        chk("stall_first_valid", 32'(bus.rsp_valid), 32'd1);
        chk("stall_first_data",  bus.rsp_data,       32'h019806B3);
        bus.req_addr = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
            tick();
            chk($sformatf("stall%0d_valid", i), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("stall%0d_data", i),  bus.rsp_data,       32'h019806B3);
            chk($sformatf("stall%0d_fault", i), 32'(bus.rsp_fault), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("release_req_ready", 32'(bus.req_ready), 32'd1);
        tick();
        chk("release_valid", 32'(bus.rsp_valid), 32'd1);
        chk("release_data",  bus.rsp_data,       32'h40340293);
        bus.req_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(bus.rsp_valid), 32'd0);

        // Clear drops a pending response; clr_start during clear is ignored.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0000;
        tick();
        bus.req_valid = 1'b0;
        chk("pre_clr_valid", 32'(bus.rsp_valid), 32'd1);
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        chk("clr_busy",      32'(bus.busy),      32'd1);
        chk("clr_rsp_drop",  32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus.clr_start = i[0];
            tick();
        end
        bus.clr_start = 1'b0;
        chk("mid_clr_busy",      32'(bus.busy),      32'd1);
        chk("mid_clr_ld_ready",  32'(bus.ld_ready),  32'd0);
        chk("mid_clr_req_ready", 32'(bus.req_ready), 32'd0);

        // Reset mid-clear: immediate reset state, then a full-length clear.
        reset = 1'b1;
        #1;
        chk("midrst_busy",     32'(bus.busy), 32'd1);
        chk("midrst_rsp_data", bus.rsp_data,  32'h0);
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("reclear_cycles", 32'(n), 32'd64);

        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0020;
        tick();
        chk("after_clear_idx8",  bus.rsp_data, NOP);
        bus.req_addr  = 32'h0000_0010;
        tick();
        chk("after_clear_idx4",  bus.rsp_data, NOP);
        bus.req_valid = 1'b0;
        tick();
        chk("final_idle_valid", 32'(bus.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
